// File: rtl/pmp_csr_file_pkg.sv
// Shared PMP definitions: CSR address map, A-field codes, cfg bit positions
// and the cfg byte legalization used on every write.
package pmp_csr_file_pkg;

    localparam logic [11:0] PmpCfgBase  = 12'h3A0;
    localparam logic [11:0] PmpCfgLast  = 12'h3AF;
    localparam logic [11:0] PmpAddrBase = 12'h3B0;
    localparam logic [11:0] PmpAddrLast = 12'h3EF;

    typedef enum logic [1:0] {
        PmpOff   = 2'b00,
        PmpTor   = 2'b01,
        PmpNa4   = 2'b10,
        PmpNapot = 2'b11
    } pmp_a_e;

    localparam int unsigned PmpCfgL   = 7;
    localparam int unsigned PmpCfgAHi = 4;
    localparam int unsigned PmpCfgALo = 3;
    localparam int unsigned PmpCfgX   = 2;
    localparam int unsigned PmpCfgW   = 1;
    localparam int unsigned PmpCfgR   = 0;

    // Reserved bits read as zero; W without R is a reserved encoding, so W is dropped.
    function automatic logic [7:0] legalize_cfg(input logic [7:0] wval);
        logic [7:0] cfg;
        cfg      = wval;
        cfg[6:5] = 2'b00;
        if (!wval[PmpCfgR] && wval[PmpCfgW]) begin
            cfg[PmpCfgW] = 1'b0;
        end
        return cfg;
    endfunction

endpackage

// File: rtl/pmp_entry_regs.sv
// One PMP entry: cfg byte plus address register, with legalization, lock
// checks and detection of any stored-bit change.
module pmp_entry_regs
    import pmp_csr_file_pkg::*;
#(
    parameter int unsigned PA_BITS = 56
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cfg_we_i,
    input  logic [7:0]         cfg_wdata_i,
    input  logic               adr_we_i,
    input  logic [PA_BITS-3:0] adr_wdata_i,
    input  logic               next_lock_i,
    input  logic [1:0]         next_a_i,
    output logic [7:0]         cfg_o,
    output logic [PA_BITS-3:0] adr_o,
    output logic               changed_o
);

    logic [7:0]         cfg_q, cfg_d;
    logic [PA_BITS-3:0] adr_q, adr_d;
    logic               adr_locked;

    always_comb begin
        // A locked TOR entry above also freezes this entry's address (its lower bound).
        adr_locked = cfg_q[PmpCfgL] || (next_lock_i && (next_a_i == PmpTor));
        cfg_d      = cfg_q;
        adr_d      = adr_q;
        if (cfg_we_i && !cfg_q[PmpCfgL]) begin
            cfg_d = legalize_cfg(cfg_wdata_i);
        end
        if (adr_we_i && !adr_locked) begin
            adr_d = adr_wdata_i;
        end
        changed_o = (cfg_d != cfg_q) || (adr_d != adr_q);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cfg_q <= '0;
            adr_q <= '0;
        end else begin
            cfg_q <= cfg_d;
            adr_q <= adr_d;
        end
    end

    assign cfg_o = cfg_q;
    assign adr_o = adr_q;

endmodule

// File: rtl/pmp_csr_file.sv
// PMP CSR file: address decode, byte steering to per-entry registers,
// combinational read mux and the registered PMPUpdate pulse.
module pmp_csr_file
    import pmp_csr_file_pkg::*;
#(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned PA_BITS     = 56,
    parameter int unsigned PMP_ENTRIES = 16,
    localparam int unsigned NumSlots   = (PMP_ENTRIES > 0) ? PMP_ENTRIES : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            CSRWriteM,
    input  logic                            StallW,
    input  logic [11:0]                     CSRAdrM,
    input  logic [XLEN-1:0]                 CSRWriteValM,
    output logic [XLEN-1:0]                 CSRReadValM,
    output logic                            IllegalPMPAccessM,
    output logic [NumSlots-1:0][7:0]        PMPCfg,
    output logic [NumSlots-1:0][PA_BITS-3:0] PMPAdr,
    output logic                            PMPUpdate
);

    localparam int unsigned BytesPerReg = XLEN / 8;
    localparam int unsigned AdrW        = PA_BITS - 2;

    logic                is_cfg, is_adr, cfg_ok, wr_en;
    logic [3:0]          cfg_group;
    logic [5:0]          adr_idx;
    logic [NumSlots-1:0] changed;
    logic                update_q, update_d;

    always_comb begin
        is_cfg            = (CSRAdrM >= PmpCfgBase) && (CSRAdrM <= PmpCfgLast);
        is_adr            = (CSRAdrM >= PmpAddrBase) && (CSRAdrM <= PmpAddrLast);
        IllegalPMPAccessM = is_cfg && (XLEN == 64) && CSRAdrM[0];
        cfg_ok            = is_cfg && !IllegalPMPAccessM;
        // Group = which run of BytesPerReg consecutive entries this pmpcfg register covers.
        cfg_group         = (XLEN == 64) ? {1'b0, CSRAdrM[3:1]} : CSRAdrM[3:0];
        adr_idx           = CSRAdrM[5:0] - PmpAddrBase[5:0];
        wr_en             = CSRWriteM && !StallW;
    end

    if (PMP_ENTRIES == 0) begin : g_no_pmp
        assign PMPCfg  = '0;
        assign PMPAdr  = '0;
        assign changed = '0;
    end else begin : g_pmp
        for (genvar i = 0; i < PMP_ENTRIES; i++) begin : g_entry
            localparam int unsigned Lane  = i % BytesPerReg;
            localparam logic [3:0]  Group = 4'(i / BytesPerReg);
            logic       next_lock;
            logic [1:0] next_a;

            if (i + 1 < PMP_ENTRIES) begin : g_next
                assign next_lock = PMPCfg[i+1][PmpCfgL];
                assign next_a    = PMPCfg[i+1][PmpCfgAHi:PmpCfgALo];
            end else begin : g_last
                assign next_lock = 1'b0;
                assign next_a    = PmpOff;
            end

            pmp_entry_regs #(
                .PA_BITS (PA_BITS)
            ) u_entry (
                .clk_i       (clk),
                .rst_i       (reset),
                .cfg_we_i    (wr_en && cfg_ok && (cfg_group == Group)),
                .cfg_wdata_i (CSRWriteValM[Lane*8 +: 8]),
                .adr_we_i    (wr_en && is_adr && (adr_idx == 6'(i))),
                .adr_wdata_i (AdrW'(CSRWriteValM)),
                .next_lock_i (next_lock),
                .next_a_i    (next_a),
                .cfg_o       (PMPCfg[i]),
                .adr_o       (PMPAdr[i]),
                .changed_o   (changed[i])
            );
        end
    end

    always_comb begin
        CSRReadValM = '0;
        if (cfg_ok) begin
            for (int i = 0; i < PMP_ENTRIES; i++) begin
                if (cfg_group == 4'(i / BytesPerReg)) begin
                    CSRReadValM[(i % BytesPerReg)*8 +: 8] = PMPCfg[i];
                end
            end
        end else if (is_adr) begin
            for (int i = 0; i < PMP_ENTRIES; i++) begin
                if (adr_idx == 6'(i)) begin
                    CSRReadValM = XLEN'(PMPAdr[i]);
                end
            end
        end
    end

    assign update_d = |changed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            update_q <= 1'b0;
        end else begin
            update_q <= update_d;
        end
    end

    assign PMPUpdate = update_q;

endmodule

// File: tb/tb_pmp_csr_file.sv
// Bench for pmp_csr_file (XLEN=64, PA_BITS=56, 16 entries): directed steps
// followed by random traffic, compared against an array-based reference model.
module tb_pmp_csr_file;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               CSRWriteM = 1'b0;
    logic               StallW = 1'b0;
    logic [11:0]        CSRAdrM = '0;
    logic [63:0]        CSRWriteValM = '0;
    logic [63:0]        CSRReadValM;
    logic               IllegalPMPAccessM;
    logic [15:0][7:0]   PMPCfg;
    logic [15:0][53:0]  PMPAdr;
    logic               PMPUpdate;

    int unsigned tests = 0;
    int unsigned fails = 0;

    logic [7:0]  cfg_m [16];
    logic [53:0] adr_m [16];
    logic        exp_upd;

    pmp_csr_file #(
        .XLEN        (64),
        .PA_BITS     (56),
        .PMP_ENTRIES (16)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .CSRWriteM         (CSRWriteM),
        .StallW            (StallW),
        .CSRAdrM           (CSRAdrM),
        .CSRWriteValM      (CSRWriteValM),
        .CSRReadValM       (CSRReadValM),
        .IllegalPMPAccessM (IllegalPMPAccessM),
        .PMPCfg            (PMPCfg),
        .PMPAdr            (PMPAdr),
        .PMPUpdate         (PMPUpdate)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 16; i++) begin
            cfg_m[i] = '0;
            adr_m[i] = '0;
        end
        exp_upd = 1'b0;
    endfunction

    function automatic void model_read(input logic [11:0] a, output logic [63:0] r,
                                       output logic il);
        int n;
        r  = '0;
        il = 1'b0;
        if (a >= 12'h3A0 && a <= 12'h3AF) begin
            if (a[0]) begin
                il = 1'b1;
            end else begin
                n = int'(a) - 'h3A0;
                for (int k = 0; k < 8; k++) begin
                    if (n * 4 + k < 16) r[8*k +: 8] = cfg_m[n*4+k];
                end
            end
        end else if (a >= 12'h3B0 && a <= 12'h3EF) begin
            n = int'(a) - 'h3B0;
            if (n < 16) r = 64'(adr_m[n]);
        end
    endfunction

    // Returns 1 when any stored bit changes.
    function automatic logic model_write(input logic [11:0] a, input logic [63:0] d);
        logic       ch;
        logic       lock;
        logic [7:0] b;
        int         n;
        ch = 1'b0;
        if (a >= 12'h3A0 && a <= 12'h3AF && !a[0]) begin
            n = int'(a) - 'h3A0;
            for (int k = 0; k < 8; k++) begin
                if (n * 4 + k < 16 && !cfg_m[n*4+k][7]) begin
                    b = d[8*k +: 8] & 8'h9F;
                    if (b[1:0] == 2'b10) b = b & 8'hFD;
                    if (b != cfg_m[n*4+k]) ch = 1'b1;
                    cfg_m[n*4+k] = b;
                end
            end
        end else if (a >= 12'h3B0 && a <= 12'h3EF) begin
            n = int'(a) - 'h3B0;
            if (n < 16) begin
                lock = cfg_m[n][7];
                if (n < 15 && cfg_m[n+1][7] && cfg_m[n+1][4:3] == 2'b01) lock = 1'b1;
                if (!lock) begin
                    if (adr_m[n] != d[53:0]) ch = 1'b1;
                    adr_m[n] = d[53:0];
                end
            end
        end
        return ch;
    endfunction

    task automatic check_state(input string ctx);
        check({ctx, " upd"}, 64'(PMPUpdate), 64'(exp_upd));
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s cfg%0d", ctx, i), 64'(PMPCfg[i]), 64'(cfg_m[i]));
            check($sformatf("%s adr%0d", ctx, i), 64'(PMPAdr[i]), 64'(adr_m[i]));
        end
    endtask

    task automatic do_op(input logic we, input logic [11:0] a, input logic [63:0] d,
                         input logic stall);
        logic [63:0] er;
        logic        ei;
        @(negedge clk);
        CSRWriteM    = we;
        StallW       = stall;
        CSRAdrM      = a;
        CSRWriteValM = d;
        #1;
        model_read(a, er, ei);
        check($sformatf("rd %h", a), CSRReadValM, er);
        check($sformatf("ill %h", a), 64'(IllegalPMPAccessM), 64'(ei));
        @(posedge clk);
        exp_upd = (we && !stall) ? model_write(a, d) : 1'b0;
        #1;
        CSRWriteM = 1'b0;
        StallW    = 1'b0;
        check_state($sformatf("op %h", a));
    endtask

    task automatic read_expect(input string tag, input logic [11:0] a,
                               input logic [63:0] r, input logic il);
        @(negedge clk);
        CSRWriteM = 1'b0;
        CSRAdrM   = a;
        #1;
        check({tag, " rd"}, CSRReadValM, r);
        check({tag, " ill"}, 64'(IllegalPMPAccessM), 64'(il));
    endtask

    task automatic reset_mid_write(input logic [11:0] a, input logic [63:0] d);
        @(negedge clk);
        CSRWriteM    = 1'b1;
        StallW       = 1'b0;
        CSRAdrM      = a;
        CSRWriteValM = d;
        reset        = 1'b1;
        #1;
        model_clear();
        check_state("rst async");
        @(posedge clk);
        #1;
        check_state("rst edge");
        reset     = 1'b0;
        CSRWriteM = 1'b0;
    endtask

    initial begin
        model_clear();
        #1 reset = 1'b1;
        #1;
        check_state("reset");
        @(posedge clk);
        #1 reset = 1'b0;

        do_op(1'b1, 12'h3A0, 64'h0F0F, 1'b0);
        check("e0 cfg", 64'(PMPCfg[0]), 64'h0F);
        check("e1 cfg", 64'(PMPCfg[1]), 64'h0F);
        check("pulse on", 64'(PMPUpdate), 64'h1);
        do_op(1'b0, 12'h3A0, 64'h0, 1'b0);
        check("pulse off", 64'(PMPUpdate), 64'h0);
        read_expect("cfg0 rb", 12'h3A0, 64'h0F0F, 1'b0);

        do_op(1'b1, 12'h3A0, 64'h02, 1'b0);
        check("wr 02", 64'(PMPCfg[0]), 64'h00);
        do_op(1'b1, 12'h3A0, 64'hE7, 1'b0);
        check("wr e7", 64'(PMPCfg[0]), 64'h87);

        do_op(1'b1, 12'h3A0, 64'h0000_0000_8800_0000, 1'b0);
        check("e3 cfg", 64'(PMPCfg[3]), 64'h88);
        do_op(1'b1, 12'h3B2, 64'h1234, 1'b0);
        check("tor lock upd", 64'(PMPUpdate), 64'h0);
        check("tor lock adr2", 64'(PMPAdr[2]), 64'h0);
        do_op(1'b1, 12'h3B3, 64'h1234, 1'b0);
        check("lock adr3", 64'(PMPAdr[3]), 64'h0);
        do_op(1'b1, 12'h3A0, 64'h0, 1'b0);
        check("lock cfg3", 64'(PMPCfg[3]), 64'h88);
        check("lock upd", 64'(PMPUpdate), 64'h0);
        do_op(1'b1, 12'h3B4, 64'h1234, 1'b0);
        check("e4 adr", 64'(PMPAdr[4]), 64'h1234);
        do_op(1'b1, 12'h3A0, 64'h0000_0005_8800_0000, 1'b0);
        check("e4 cfg", 64'(PMPCfg[4]), 64'h05);
        check("e4 upd", 64'(PMPUpdate), 64'h1);

        do_op(1'b1, 12'h3B5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        read_expect("adr5 rb", 12'h3B5, 64'h003F_FFFF_FFFF_FFFF, 1'b0);

        read_expect("cfg1 odd", 12'h3A1, 64'h0, 1'b1);
        do_op(1'b1, 12'h3A1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        check("odd upd", 64'(PMPUpdate), 64'h0);
        do_op(1'b1, 12'h3B6, 64'h55, 1'b1);
        check("stall adr6", 64'(PMPAdr[6]), 64'h0);
        check("stall upd", 64'(PMPUpdate), 64'h0);

        do_op(1'b1, 12'h3C4, 64'hABC, 1'b0);
        read_expect("adr20", 12'h3C4, 64'h0, 1'b0);
        do_op(1'b1, 12'h3A4, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        read_expect("cfg4", 12'h3A4, 64'h0, 1'b0);

        do_op(1'b1, 12'h3A0, 64'h8181_8181_8181_8181, 1'b0);
        do_op(1'b1, 12'h3A2, 64'h8181_8181_8181_8181, 1'b0);
        do_op(1'b1, 12'h3B7, 64'h77, 1'b0);
        check("all locked upd", 64'(PMPUpdate), 64'h0);
        reset_mid_write(12'h3A0, 64'h0F);
        do_op(1'b1, 12'h3A0, 64'h0F, 1'b0);
        check("post rst cfg0", 64'(PMPCfg[0]), 64'h0F);
        check("post rst upd", 64'(PMPUpdate), 64'h1);

        for (int it = 0; it < 400; it++) begin
            logic [11:0] a;
            logic [63:0] d;
            int          sel;
            sel = $urandom_range(0, 9);
            if (sel < 4) a = 12'h3A0 + 12'($urandom_range(0, 15));
            else if (sel < 9) a = 12'h3B0 + 12'($urandom_range(0, 20));
            else a = ($urandom_range(0, 1) == 0) ? 12'h39F : 12'($urandom_range('h3F0, 'h3FF));
            d = {$urandom, $urandom};
            if ($urandom_range(0, 7) != 0) d = d & ~64'h8080_8080_8080_8080;
            if ($urandom_range(0, 49) == 0) begin
                reset_mid_write(a, d);
            end else begin
                do_op($urandom_range(0, 3) != 0, a, d, $urandom_range(0, 7) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
